// File: rtl/axis_frame_packer_if.sv
// Byte-wide AXI-Stream link with tid/tuser sideband; used for both the
// packer's input side (slave) and its framed output side (master).
interface axis_frame_packer_if #(
    parameter int TID_WIDTH   = 8,
    parameter int TUSER_WIDTH = 8
) ();
    logic [7:0]             tdata;
    logic [TID_WIDTH-1:0]   tid;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, tid, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tid, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_frame_packer.sv
// Store-and-forward packer: buffers one AXIS packet, then emits
// SOF / tid / len / {ovf,tuser} followed by the buffered payload.
module axis_frame_packer #(
    parameter int         TID_WIDTH   = 8,
    parameter int         TUSER_WIDTH = 8,
    parameter int         DEPTH       = 64,
    parameter logic [7:0] SOF_BYTE    = 8'hBC
) (
    input  logic                clk,
    input  logic                resn,
    axis_frame_packer_if.slave  s_axis,
    axis_frame_packer_if.master m_axis,
    output logic [15:0]         overflow_count,
    output logic                busy
);
    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LEN_FULL_M1 = 8'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_HDR_SOF,
        ST_HDR_ID,
        ST_HDR_LEN,
        ST_HDR_STAT,
        ST_PAYLOAD
    } state_t;

    state_t        r_state;
    logic [7:0]    r_len;
    logic [7:0]    r_tid;
    logic [6:0]    r_tuser;
    logic          r_ovf;
    logic [15:0]   r_ovf_cnt;
    logic          r_tready;
    logic          r_tvalid;
    logic          r_tlast;
    logic [7:0]    r_tdata;
    logic [AW-1:0] r_rd_idx;
    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_rd_data;

    logic          w_s_fire;
    logic          w_m_fire;
    logic          w_wr_en;
    logic          w_load;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_tid8;
    logic [6:0]    w_tuser7;

    generate
        if (TID_WIDTH > 8) begin : g_tid_trim
            logic w_unused_tid;
            assign w_tid8       = s_axis.tid[7:0];
            assign w_unused_tid = ^s_axis.tid[TID_WIDTH-1:8];
        end else begin : g_tid_ext
            assign w_tid8 = 8'(s_axis.tid);
        end
        if (TUSER_WIDTH > 7) begin : g_tuser_trim
            logic w_unused_tuser;
            assign w_tuser7       = s_axis.tuser[6:0];
            assign w_unused_tuser = ^s_axis.tuser[TUSER_WIDTH-1:7];
        end else begin : g_tuser_ext
            assign w_tuser7 = 7'(s_axis.tuser);
        end
    endgenerate

    assign w_s_fire  = s_axis.tvalid & r_tready;
    assign w_m_fire  = r_tvalid & m_axis.tready;
    assign w_wr_en   = w_s_fire & ((r_state == ST_IDLE) | (r_state == ST_FILL));
    assign w_wr_addr = (r_state == ST_FILL) ? r_len[AW-1:0] : '0;
    // Look one byte ahead on every payload load so r_rd_data already holds
    // the following byte when the next handshake arrives.
    assign w_load    = w_m_fire & ((r_state == ST_HDR_STAT) |
                                   ((r_state == ST_PAYLOAD) & ~r_tlast));
    assign w_rd_addr = w_load ? (r_rd_idx + AW'(1)) : r_rd_idx;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= s_axis.tdata;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_tid     <= '0;
            r_tuser   <= '0;
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
            r_tready  <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= '0;
            r_rd_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_s_fire) begin
                        r_tid   <= w_tid8;
                        r_tuser <= w_tuser7;
                        r_len   <= 8'd1;
                        if (s_axis.tlast) begin
                            r_state  <= ST_HDR_SOF;
                            r_tready <= 1'b0;
                            r_tvalid <= 1'b1;
                            r_tdata  <= SOF_BYTE;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_s_fire) begin
                        r_len <= r_len + 8'd1;
                        if (s_axis.tlast) begin
                            r_state  <= ST_HDR_SOF;
                            r_tready <= 1'b0;
                            r_tvalid <= 1'b1;
                            r_tdata  <= SOF_BYTE;
                        end else if (r_len == LEN_FULL_M1) begin
                            r_state <= ST_DRAIN;
                            r_ovf   <= 1'b1;
                            if (r_ovf_cnt != 16'hFFFF) begin
                                r_ovf_cnt <= r_ovf_cnt + 16'd1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_s_fire && s_axis.tlast) begin
                        r_state  <= ST_HDR_SOF;
                        r_tready <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= SOF_BYTE;
                    end
                end
                ST_HDR_SOF: begin
                    if (w_m_fire) begin
                        r_state <= ST_HDR_ID;
                        r_tdata <= r_tid;
                    end
                end
                ST_HDR_ID: begin
                    if (w_m_fire) begin
                        r_state <= ST_HDR_LEN;
                        r_tdata <= r_len;
                    end
                end
                ST_HDR_LEN: begin
                    if (w_m_fire) begin
                        r_state <= ST_HDR_STAT;
                        r_tdata <= {r_ovf, r_tuser};
                    end
                end
                ST_HDR_STAT: begin
                    if (w_m_fire) begin
                        r_state  <= ST_PAYLOAD;
                        r_tdata  <= r_rd_data;
                        r_tlast  <= (r_len == 8'd1);
                        r_rd_idx <= AW'(1);
                    end
                end
                ST_PAYLOAD: begin
                    if (w_m_fire) begin
                        if (r_tlast) begin
                            r_state  <= ST_IDLE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tready <= 1'b1;
                            r_len    <= '0;
                            r_ovf    <= 1'b0;
                            r_rd_idx <= '0;
                        end else begin
                            r_tdata  <= r_rd_data;
                            r_tlast  <= (8'(r_rd_idx) == (r_len - 8'd1));
                            r_rd_idx <= r_rd_idx + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready  = r_tready;
    assign m_axis.tdata   = r_tdata;
    assign m_axis.tvalid  = r_tvalid;
    assign m_axis.tlast   = r_tlast;
    assign m_axis.tid     = '0;
    assign m_axis.tuser   = '0;
    assign overflow_count = r_ovf_cnt;
    assign busy           = (r_state != ST_IDLE);
endmodule
